// File: rtl/track_stream_reader.sv
// Consumer of a captured draw bitmap: latches the frame, OR-pools it by SCALE x SCALE
// and streams the pooled image one pixel per handshake, row-major.
module track_stream_reader #(
  parameter int unsigned SIZE  = 52,
  parameter int unsigned SCALE = 2,
  parameter int unsigned OUT   = SIZE / SCALE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [6:0]             in_block_pos,
  input  logic [SIZE*SIZE-1:0]   in_track,
  output logic                   busy,
  output logic                   px_valid,
  input  logic                   px_ready,
  output logic                   px_data,
  output logic [4:0]             px_x,
  output logic [4:0]             px_y,
  output logic                   px_last,
  output logic [6:0]             img_block_pos,
  output logic                   done,
  output logic [9:0]             ink_count,
  output logic                   overrun
);

  localparam int unsigned N    = SIZE * SIZE;
  localparam int unsigned IDXW = $clog2(N);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t         state;
  logic [N-1:0]   frame;
  logic [4:0]     x;
  logic [4:0]     y;
  logic [9:0]     ink_cnt;
  logic           pool;
  logic [IDXW-1:0] idx;
  logic           handshake;

  // OR over the SCALE x SCALE source block that maps onto output pixel (x, y)
  always_comb begin
    pool = 1'b0;
    idx  = '0;
    for (int unsigned i = 0; i < SCALE; i++) begin
      for (int unsigned j = 0; j < SCALE; j++) begin
        idx  = IDXW'((SCALE * 32'(y) + i) * SIZE + SCALE * 32'(x) + j);
        pool = pool | frame[idx];
      end
    end
  end

  assign px_valid  = (state == STREAM);
  assign busy      = (state != IDLE);
  assign px_data   = px_valid & pool;
  assign px_x      = x;
  assign px_y      = y;
  assign px_last   = px_valid && (x == 5'(OUT - 1)) && (y == 5'(OUT - 1));
  assign handshake = px_valid & px_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      frame         <= '0;
      x             <= '0;
      y             <= '0;
      ink_cnt       <= '0;
      ink_count     <= '0;
      img_block_pos <= '0;
      done          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            frame         <= in_track;
            img_block_pos <= in_block_pos;
            x             <= '0;
            y             <= '0;
            ink_cnt       <= '0;
            overrun       <= 1'b0;
            state         <= STREAM;
          end
        end
        STREAM: begin
          if (in_valid) overrun <= 1'b1;
          if (handshake) begin
            ink_cnt <= ink_cnt + 10'(px_data);
            if (px_last) begin
              // coordinates park at the origin so IDLE shows a clean (0,0)
              x         <= '0;
              y         <= '0;
              ink_count <= ink_cnt + 10'(px_data);
              done      <= 1'b1;
              state     <= DONE;
            end else if (x < 5'(OUT - 1)) begin
              x <= x + 5'd1;
            end else begin
              x <= '0;
              y <= y + 5'd1;
            end
          end
        end
        DONE: begin
          if (in_valid) overrun <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
